fft_pwr_avg_peak: RTL and testbench
===================================

# fft_pwr_avg_peak

Downstream consumer of the registered per-bin power words from the FFT power stage. It averages each of the 17 one-sided power bins over 2^LOG2_AVG frames, then scans the averaged spectrum one bin per cycle for the peak. It reports the peak bin index and its averaged power with a one-cycle strobe. It is the test bench's spectral-measurement endpoint, used for tone-location and SFDR checks.

## Interface
- NBIN, 17: number of one-sided bins; bin 0 = DC, bin 16 = Nyquist.
- PW, 35: power word width; input words are non-negative and treated as unsigned.
- LOG2_AVG, 4: log2 of the frame count averaged per result; legal range 0..8.
- clk  in  1  clock.
- arstb  in  1  reset, asynchronous, active-low.
- frame_vld  in  1  one-cycle strobe from FFT control; pwr_bus holds a complete new frame in this cycle.
- pwr_bus  in  NBIN*PW  packed bin powers; bin k occupies bits [k*PW +: PW].
- clear  in  1  synchronous flush of accumulation, scan and flags.
- avg_vld  out  1  one-cycle pulse; peak_idx and peak_pwr are updated in this cycle.
- peak_idx  out  5  index (0..16) of the largest averaged bin.
- peak_pwr  out  PW  averaged power of that bin.
- busy  out  1  high while a scan is in progress.
- ovf  out  1  sticky; an averaged frame set was discarded because a scan was still running.

## Operation
- Accumulators: NBIN registers, each PW+LOG2_AVG bits unsigned. Frame counter fcnt is LOG2_AVG bits wide (no counter when LOG2_AVG=0).
- On a frame_vld cycle that is not the last of a set: acc[k] += pwr[k] and fcnt increments.
- On a frame_vld cycle with fcnt = 2^LOG2_AVG-1 (the completion frame), all of the following happen:
  - avg[k] = (acc[k]+pwr[k]) >> LOG2_AVG, floor, always fits in PW bits.
  - Accumulators clear to 0 and fcnt returns to 0.
  - If the FSM is in WAIT, avg[] is captured into the snapshot registers and the FSM enters SCAN. Otherwise the set is discarded, ovf is set and the snapshot is left untouched.
- Accumulation runs independently of the FSM, so frames arriving during SCAN are still accumulated.
- FSM states WAIT, SCAN, OUT:
  - WAIT goes to SCAN on an accepted completion frame.
  - SCAN holds idx 0..16. In each cycle, snapshot[idx] is compared against best; it replaces best only if strictly greater, so ties keep the lower index. best is seeded from bin 0 at idx=0.
  - SCAN goes to OUT after idx=16 is evaluated. OUT lasts one cycle: avg_vld=1, then the FSM returns to WAIT.
- busy = (state != WAIT).
- peak_idx and peak_pwr hold their values until the next OUT.
- clear takes priority over frame_vld in the same cycle. It zeroes the accumulators, fcnt, snapshot, best and ovf, and returns the FSM to WAIT. It also zeroes peak_idx and peak_pwr and suppresses any pending avg_vld.

## Timing
- Reset (arstb low): every register is 0. avg_vld=0, peak_idx=0, peak_pwr=0, busy=0, ovf=0, FSM=WAIT.
- Latency: if the accepted completion frame_vld is in cycle t, then busy=1 in cycles t+1..t+18 and avg_vld=1 in cycle t+18. The FSM is in WAIT in cycle t+19.
- A completion frame in cycle t+19 or later is accepted. One in cycles t+1..t+18 triggers ovf.
- Minimum result period is therefore 19 cycles when LOG2_AVG=0.
- Asserting arstb mid-scan aborts the scan with no avg_vld. Accumulated partial frames are lost.
- frame_vld in the same cycle as avg_vld accumulates normally.

## Structure
- Package fft_tb_pkg: NBIN, PW, IDX_W=5, and the state enum {WAIT, SCAN, OUT}.
- Sub-module fft_peak_scan: snapshot registers, scan FSM and output registers. The top module keeps the accumulators, fcnt and ovf.

## Test plan
- LOG2_AVG=2; four frames with bin5=1000 and all other bins 10 → avg_vld exactly 18 cycles after the 4th frame_vld, peak_idx=5, peak_pwr=1000.
- LOG2_AVG=2; bin3 = 1,2,3,5 across the four frames, all other bins 0 → peak_idx=3, peak_pwr=2 (floor of 11/4).
- Bins 2 and 9 both 500, all others 0 → peak_idx=2 (tie rule).
- LOG2_AVG=4; all bins 2^34-1 for 16 frames → peak_idx=0, peak_pwr=2^34-1 (no accumulator overflow).
- LOG2_AVG=0; frame_vld every cycle → avg_vld once every 19 cycles, ovf=1 from cycle t+1, busy low only one cycle per period.
- Pulse clear in the 5th scan cycle → no avg_vld and outputs read 0. A fresh frame set then gives the correct result with no residue. Repeat with arstb pulsed mid-accumulation and check the same.

Source files
------------

// File: rtl/fft_tb_pkg.sv
// rtl/fft_tb_pkg.sv - shared sizes and scan state encoding for the averaged-peak endpoint
package fft_tb_pkg;

  localparam int NBIN  = 17;
  localparam int PW    = 35;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/fft_pwr_avg_peak_if.sv
// rtl/fft_pwr_avg_peak_if.sv - frame input and peak result signals of the averaged-peak endpoint
interface fft_pwr_avg_peak_if;
  import fft_tb_pkg::*;

  logic               frame_vld;
  logic [NBIN*PW-1:0] pwr_bus;
  logic               clear;
  logic               avg_vld;
  logic [IDX_W-1:0]   peak_idx;
  logic [PW-1:0]      peak_pwr;
  logic               busy;
  logic               ovf;

  modport master (
    output frame_vld, pwr_bus, clear,
    input  avg_vld, peak_idx, peak_pwr, busy, ovf
  );

  modport slave (
    input  frame_vld, pwr_bus, clear,
    output avg_vld, peak_idx, peak_pwr, busy, ovf
  );

endinterface

// File: rtl/fft_peak_scan.sv
// rtl/fft_peak_scan.sv - snapshot of one averaged spectrum and a one-bin-per-cycle peak search
module fft_peak_scan
  import fft_tb_pkg::*;
(
  input  logic               clk,
  input  logic               arstb,
  input  logic               i_clear,
  input  logic               i_done,
  input  logic [NBIN*PW-1:0] i_avg,
  output logic               o_busy,
  output logic               o_avg_vld,
  output logic [IDX_W-1:0]   o_peak_idx,
  output logic [PW-1:0]      o_peak_pwr
);

  scan_state_e      r_state;
  scan_state_e      w_next;
  logic [PW-1:0]    r_snap [NBIN];
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_best_idx;
  logic [PW-1:0]    r_best;
  logic [IDX_W-1:0] r_peak_idx;
  logic [PW-1:0]    r_peak_pwr;
  logic             r_avg_vld;
  logic             w_load;
  logic             w_last;
  logic             w_take;
  logic [PW-1:0]    w_cur;

  // a completed set is only taken when no search is in flight
  assign w_load = i_done && (r_state == WAIT);
  assign w_cur  = r_snap[r_idx];
  assign w_last = (r_idx == IDX_W'(NBIN - 1));
  // bin 0 seeds the search; later bins win only when strictly larger, so ties keep the lower bin
  assign w_take = (r_idx == '0) || (w_cur > r_best);

  assign o_busy     = (r_state != WAIT);
  assign o_avg_vld  = r_avg_vld;
  assign o_peak_idx = r_peak_idx;
  assign o_peak_pwr = r_peak_pwr;

  // state register; clear aborts any search in progress
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      r_state <= WAIT;
    end else if (i_clear) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // next state: WAIT -> SCAN on accepted set, SCAN -> OUT after the last bin, OUT for one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT:    if (w_load) w_next = SCAN;
      SCAN:    if (w_last) w_next = OUT;
      OUT:     w_next = WAIT;
      default: w_next = WAIT;
    endcase
  end

  // snapshot capture, running best and result registers
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      for (int k = 0; k < NBIN; k++) r_snap[k] <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_peak_idx <= '0;
      r_peak_pwr <= '0;
      r_avg_vld  <= 1'b0;
    end else if (i_clear) begin
      for (int k = 0; k < NBIN; k++) r_snap[k] <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_peak_idx <= '0;
      r_peak_pwr <= '0;
      r_avg_vld  <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (w_load) begin
        for (int k = 0; k < NBIN; k++) r_snap[k] <= i_avg[k*PW +: PW];
        r_idx <= '0;
      end
      if (r_state == SCAN) begin
        if (w_take) begin
          r_best     <= w_cur;
          r_best_idx <= r_idx;
        end
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        if (w_last) begin
          r_avg_vld  <= 1'b1;
          r_peak_idx <= w_take ? r_idx : r_best_idx;
          r_peak_pwr <= w_take ? w_cur : r_best;
        end
      end
    end
  end

endmodule

// File: rtl/fft_pwr_avg_peak.sv
// rtl/fft_pwr_avg_peak.sv - per-bin power averaging over 2^LOG2_AVG frames with peak search
module fft_pwr_avg_peak
  import fft_tb_pkg::*;
#(
  parameter int LOG2_AVG = 4
)
(
  input logic               clk,
  input logic               arstb,
  fft_pwr_avg_peak_if.slave bus
);

  localparam int             AW   = PW + LOG2_AVG;
  localparam int             FCW  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  // with LOG2_AVG=0 this is 0, so every frame completes a set and the counter never moves
  localparam logic [FCW-1:0] FMAX = FCW'((1 << LOG2_AVG) - 1);

  logic [AW-1:0]      r_acc [NBIN];
  logic [FCW-1:0]     r_fcnt;
  logic               r_ovf;
  logic               w_last;
  logic               w_done;
  logic               w_busy;
  logic [NBIN*PW-1:0] w_avg;

  assign w_last = (r_fcnt == FMAX);
  assign w_done = bus.frame_vld && !bus.clear && w_last;
  assign bus.busy = w_busy;
  assign bus.ovf  = r_ovf;

  // average including the completing frame; the sum of 2^LOG2_AVG PW-bit words fits AW bits
  always_comb begin
    w_avg = '0;
    for (int k = 0; k < NBIN; k++) begin
      w_avg[k*PW +: PW] = PW'((r_acc[k] + AW'(bus.pwr_bus[k*PW +: PW])) >> LOG2_AVG);
    end
  end

  // accumulate frames; the completing frame empties the accumulators instead
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      for (int k = 0; k < NBIN; k++) r_acc[k] <= '0;
      r_fcnt <= '0;
    end else if (bus.clear) begin
      for (int k = 0; k < NBIN; k++) r_acc[k] <= '0;
      r_fcnt <= '0;
    end else if (bus.frame_vld) begin
      if (w_last) begin
        for (int k = 0; k < NBIN; k++) r_acc[k] <= '0;
        r_fcnt <= '0;
      end else begin
        for (int k = 0; k < NBIN; k++) r_acc[k] <= r_acc[k] + AW'(bus.pwr_bus[k*PW +: PW]);
        r_fcnt <= r_fcnt + FCW'(1);
      end
    end
  end

  // sticky flag for a completed set that arrived while the search was still busy
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      r_ovf <= 1'b0;
    end else if (bus.clear) begin
      r_ovf <= 1'b0;
    end else if (w_done && w_busy) begin
      r_ovf <= 1'b1;
    end
  end

  fft_peak_scan u_scan (
    .clk        (clk),
    .arstb      (arstb),
    .i_clear    (bus.clear),
    .i_done     (w_done),
    .i_avg      (w_avg),
    .o_busy     (w_busy),
    .o_avg_vld  (bus.avg_vld),
    .o_peak_idx (bus.peak_idx),
    .o_peak_pwr (bus.peak_pwr)
  );

endmodule

// File: tb/tb_fft_pwr_avg_peak.sv
// tb/tb_fft_pwr_avg_peak.sv - self-checking bench for fft_pwr_avg_peak at LOG2_AVG 2, 4 and 0
module tb_fft_pwr_avg_peak;
  import fft_tb_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic arstb = 1'b0;
  longint cyc = 0;

  logic               fv  [NI];
  logic               clr [NI];
  logic [NBIN*PW-1:0] pb  [NI];
  logic               av  [NI];
  logic               bz  [NI];
  logic               ov  [NI];
  logic [IDX_W-1:0]   pi  [NI];
  logic [PW-1:0]      pp  [NI];

  int checks = 0;
  int errors = 0;

  // reference model state
  int                l2 [NI] = '{2, 4, 0};
  longint unsigned   msum [NI][NBIN];
  int                mcnt [NI];
  longint            t_acc [NI];
  bit                mov [NI];
  logic [IDX_W-1:0]  exp_idx [NI];
  logic [PW-1:0]     exp_pwr [NI];
  logic [PW-1:0]     cur [NBIN];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fft_pwr_avg_peak_if ifc ();
    assign ifc.frame_vld = fv[g];
    assign ifc.pwr_bus   = pb[g];
    assign ifc.clear     = clr[g];
    assign av[g] = ifc.avg_vld;
    assign bz[g] = ifc.busy;
    assign ov[g] = ifc.ovf;
    assign pi[g] = ifc.peak_idx;
    assign pp[g] = ifc.peak_pwr;
    fft_pwr_avg_peak #(.LOG2_AVG((g == 0) ? 2 : (g == 1) ? 4 : 0)) u_dut (
      .clk   (clk),
      .arstb (arstb),
      .bus   (ifc)
    );
  end

  task automatic model_reset(input int s);
    for (int k = 0; k < NBIN; k++) msum[s][k] = 0;
    mcnt[s]  = 0;
    t_acc[s] = -1000;
    mov[s]   = 1'b0;
  endtask

  task automatic rand_bins(input int mode);
    logic [63:0] r;
    for (int k = 0; k < NBIN; k++) begin
      r = {$urandom, $urandom};
      if (mode == 0) cur[k] = r[PW-1:0];
      else cur[k] = PW'($urandom_range(0, 3));
    end
  endtask

  // drive cur[] as one frame in the current cycle and update the model; returns one cycle later
  task automatic send_frame(input int s);
    longint unsigned a, bv;
    int bi;
    for (int k = 0; k < NBIN; k++) begin
      pb[s][k*PW +: PW] = cur[k];
      msum[s][k] += 64'(cur[k]);
    end
    mcnt[s]++;
    if (mcnt[s] == (1 << l2[s])) begin
      mcnt[s] = 0;
      if (cyc > t_acc[s] + 18) begin
        t_acc[s] = cyc;
        bi = 0;
        bv = msum[s][0] >> l2[s];
        for (int k = 1; k < NBIN; k++) begin
          a = msum[s][k] >> l2[s];
          if (a > bv) begin bv = a; bi = k; end
        end
        exp_idx[s] = IDX_W'(bi);
        exp_pwr[s] = PW'(bv);
      end else begin
        mov[s] = 1'b1;
      end
      for (int k = 0; k < NBIN; k++) msum[s][k] = 0;
    end
    fv[s] = 1'b1;
    @(negedge clk);
    fv[s] = 1'b0;
  endtask

  // observe until avg_vld (bounded); reports latency from the accepted completion frame
  task automatic await_result(input int s, output bit got, output longint lat,
                              output logic [IDX_W-1:0] oi, output logic [PW-1:0] op,
                              output bit busy_ok);
    got = 1'b0; lat = -1; oi = '0; op = '0; busy_ok = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bz[s] !== 1'b1) busy_ok = 1'b0;
      if (av[s] === 1'b1) begin
        got = 1'b1; lat = cyc - t_acc[s]; oi = pi[s]; op = pp[s];
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < NI; s++) begin
      checks++; if (av[s] !== 1'b0) begin errors++; $display("FAIL reset_avg_vld[%0d]: got %b want 0", s, av[s]); end
      checks++; if (bz[s] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", s, bz[s]); end
      checks++; if (ov[s] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d]: got %b want 0", s, ov[s]); end
      checks++; if (pi[s] !== '0) begin errors++; $display("FAIL reset_peak_idx[%0d]: got %0d want 0", s, pi[s]); end
      checks++; if (pp[s] !== '0) begin errors++; $display("FAIL reset_peak_pwr[%0d]: got %0d want 0", s, pp[s]); end
    end
  endtask

  task automatic test_dominant;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NBIN; k++) cur[k] = 35'd10;
      cur[5] = 35'd1000;
      send_frame(0);
    end
    await_result(0, got, lat, oi, op, bok);
    checks++; if (!got || lat != 18) begin errors++; $display("FAIL dominant_latency: seen=%0d latency=%0d want 18", got, lat); end
    checks++; if (!bok) begin errors++; $display("FAIL dominant_busy: busy dropped before result, want high"); end
    checks++; if (oi !== 5'd5) begin errors++; $display("FAIL dominant_idx: got %0d want 5", oi); end
    checks++; if (op !== 35'd1000) begin errors++; $display("FAIL dominant_pwr: got %0d want 1000", op); end
    @(negedge clk);
    checks++; if (bz[0] !== 1'b0 || av[0] !== 1'b0) begin errors++; $display("FAIL dominant_after: busy=%b avg_vld=%b want 0 0", bz[0], av[0]); end
  endtask

  task automatic test_floor;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    int v [4] = '{1, 2, 3, 5};
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NBIN; k++) cur[k] = '0;
      cur[3] = PW'(v[f]);
      send_frame(0);
    end
    await_result(0, got, lat, oi, op, bok);
    checks++; if (!got || lat != 18) begin errors++; $display("FAIL floor_latency: seen=%0d latency=%0d want 18", got, lat); end
    checks++; if (oi !== 5'd3) begin errors++; $display("FAIL floor_idx: got %0d want 3", oi); end
    checks++; if (op !== 35'd2) begin errors++; $display("FAIL floor_pwr: got %0d want 2", op); end
    @(negedge clk);
  endtask

  task automatic test_tie;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NBIN; k++) cur[k] = '0;
      cur[2] = 35'd500;
      cur[9] = 35'd500;
      send_frame(0);
    end
    await_result(0, got, lat, oi, op, bok);
    checks++; if (!got) begin errors++; $display("FAIL tie_result: no avg_vld within bound"); end
    checks++; if (oi !== 5'd2) begin errors++; $display("FAIL tie_idx: got %0d want 2", oi); end
    checks++; if (op !== 35'd500) begin errors++; $display("FAIL tie_pwr: got %0d want 500", op); end
    @(negedge clk);
  endtask

  task automatic test_max_value;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < NBIN; k++) cur[k] = 35'h3_FFFF_FFFF;
      send_frame(1);
    end
    await_result(1, got, lat, oi, op, bok);
    checks++; if (!got || lat != 18) begin errors++; $display("FAIL max_latency: seen=%0d latency=%0d want 18", got, lat); end
    checks++; if (oi !== 5'd0) begin errors++; $display("FAIL max_idx: got %0d want 0", oi); end
    checks++; if (op !== 35'h3_FFFF_FFFF) begin errors++; $display("FAIL max_pwr: got %0h want 3ffffffff", op); end
    checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL max_ovf: got %b want 0", ov[1]); end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    int s;
    for (int it = 0; it < 8; it++) begin
      s = (it < 6) ? 0 : 1;
      for (int f = 0; f < (1 << l2[s]); f++) begin
        rand_bins(it % 2);
        send_frame(s);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      await_result(s, got, lat, oi, op, bok);
      checks++; if (!got || lat != 18 || !bok) begin errors++; $display("FAIL random_timing[%0d]: seen=%0d latency=%0d busy_ok=%0d want 18", it, got, lat, bok); end
      checks++; if (oi !== exp_idx[s] || op !== exp_pwr[s]) begin errors++; $display("FAIL random_peak[%0d]: got idx %0d pwr %0d want idx %0d pwr %0d", it, oi, op, exp_idx[s], exp_pwr[s]); end
      @(negedge clk);
      checks++; if (ov[s] !== mov[s]) begin errors++; $display("FAIL random_ovf[%0d]: got %b want %b", it, ov[s], mov[s]); end
    end
  endtask

  task automatic test_back_to_back;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    logic [IDX_W-1:0] ai; logic [PW-1:0] ap;
    int n;
    for (int f = 0; f < 4; f++) begin rand_bins(0); send_frame(0); end
    ai = exp_idx[0]; ap = exp_pwr[0];
    rand_bins(0); send_frame(0);
    rand_bins(1); send_frame(0);
    n = 0;
    while (cyc < t_acc[0] + 18 && n < 40) begin @(negedge clk); n++; end
    checks++; if (av[0] !== 1'b1) begin errors++; $display("FAIL b2b_a_vld: avg_vld=%b at latency %0d want 1 at 18", av[0], cyc - t_acc[0]); end
    checks++; if (pi[0] !== ai || pp[0] !== ap) begin errors++; $display("FAIL b2b_a_peak: got idx %0d pwr %0d want idx %0d pwr %0d", pi[0], pp[0], ai, ap); end
    rand_bins(0); send_frame(0);
    rand_bins(0); send_frame(0);
    await_result(0, got, lat, oi, op, bok);
    checks++; if (!got || lat != 18) begin errors++; $display("FAIL b2b_b_latency: seen=%0d latency=%0d want 18", got, lat); end
    checks++; if (oi !== exp_idx[0] || op !== exp_pwr[0]) begin errors++; $display("FAIL b2b_b_peak: got idx %0d pwr %0d want idx %0d pwr %0d", oi, op, exp_idx[0], exp_pwr[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ov[0]); end
    @(negedge clk);
  endtask

  task automatic test_stream_ovf;
    bit ea, eb;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      rand_bins(i % 2);
      send_frame(2);
      ea = (cyc == t_acc[2] + 18);
      eb = (cyc > t_acc[2]) && (cyc <= t_acc[2] + 18);
      checks++; if (av[2] !== ea) begin errors++; $display("FAIL stream_avg_vld@%0d: got %b want %b", cyc, av[2], ea); end
      checks++; if (bz[2] !== eb) begin errors++; $display("FAIL stream_busy@%0d: got %b want %b", cyc, bz[2], eb); end
      checks++; if (ov[2] !== mov[2]) begin errors++; $display("FAIL stream_ovf@%0d: got %b want %b", cyc, ov[2], mov[2]); end
      if (ea) begin
        pulses++;
        checks++; if (pi[2] !== exp_idx[2] || pp[2] !== exp_pwr[2]) begin errors++; $display("FAIL stream_peak@%0d: got idx %0d pwr %0d want idx %0d pwr %0d", cyc, pi[2], pp[2], exp_idx[2], exp_pwr[2]); end
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL stream_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_clear;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    int seen;
    for (int f = 0; f < 4; f++) begin rand_bins(0); send_frame(0); end
    rand_bins(0); send_frame(0);
    repeat (3) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    model_reset(0);
    checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", bz[0]); end
    checks++; if (pi[0] !== '0 || pp[0] !== '0) begin errors++; $display("FAIL clear_outputs: got idx %0d pwr %0d want 0 0", pi[0], pp[0]); end
    seen = 0;
    repeat (25) begin if (av[0] === 1'b1) seen++; @(negedge clk); end
    checks++; if (seen != 0) begin errors++; $display("FAIL clear_no_vld: got %0d pulses want 0", seen); end
    for (int f = 0; f < 4; f++) begin rand_bins(0); send_frame(0); end
    await_result(0, got, lat, oi, op, bok);
    checks++; if (!got || lat != 18) begin errors++; $display("FAIL clear_fresh_latency: seen=%0d latency=%0d want 18", got, lat); end
    checks++; if (oi !== exp_idx[0] || op !== exp_pwr[0]) begin errors++; $display("FAIL clear_fresh_peak: got idx %0d pwr %0d want idx %0d pwr %0d", oi, op, exp_idx[0], exp_pwr[0]); end
    @(negedge clk);
  endtask

  task automatic test_arstb;
    bit got, bok; longint lat; logic [IDX_W-1:0] oi; logic [PW-1:0] op;
    rand_bins(0); send_frame(0);
    rand_bins(0); send_frame(0);
    for (int f = 0; f < 5; f++) begin rand_bins(0); send_frame(1); end
    arstb = 1'b0;
    @(negedge clk);
    arstb = 1'b1;
    for (int s = 0; s < NI; s++) model_reset(s);
    checks++; if (pi[0] !== '0 || pp[0] !== '0 || bz[0] !== 1'b0) begin errors++; $display("FAIL arstb_outputs: idx %0d pwr %0d busy %b want 0 0 0", pi[0], pp[0], bz[0]); end
    checks++; if (ov[2] !== 1'b0) begin errors++; $display("FAIL arstb_ovf: got %b want 0", ov[2]); end
    for (int f = 0; f < 4; f++) begin rand_bins(0); send_frame(0); end
    await_result(0, got, lat, oi, op, bok);
    checks++; if (!got || lat != 18 || oi !== exp_idx[0] || op !== exp_pwr[0]) begin errors++; $display("FAIL arstb_fresh0: seen=%0d latency=%0d idx %0d pwr %0d want 18 idx %0d pwr %0d", got, lat, oi, op, exp_idx[0], exp_pwr[0]); end
    @(negedge clk);
    for (int f = 0; f < 16; f++) begin rand_bins(0); send_frame(1); end
    await_result(1, got, lat, oi, op, bok);
    checks++; if (!got || lat != 18 || oi !== exp_idx[1] || op !== exp_pwr[1]) begin errors++; $display("FAIL arstb_fresh1: seen=%0d latency=%0d idx %0d pwr %0d want 18 idx %0d pwr %0d", got, lat, oi, op, exp_idx[1], exp_pwr[1]); end
    @(negedge clk);
  endtask

  initial begin
    for (int s = 0; s < NI; s++) begin
      fv[s] = 1'b0; clr[s] = 1'b0; pb[s] = '0;
      model_reset(s);
      exp_idx[s] = '0; exp_pwr[s] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    arstb = 1'b1;
    @(negedge clk);
    test_dominant();
    test_floor();
    test_tie();
    test_max_value();
    test_random();
    test_back_to_back();
    test_stream_ovf();
    test_clear();
    test_arstb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
